deserialiser: RTL and testbench

Receive-path counterpart of the byte-to-bit serialiser: packs a bit stream, LSB first, into bytes. It sits between the ISO/IEC 14443A frame decoder, which produces one data bit per strobe plus start/end/error markers, and the byte-oriented receive logic. Partial final bytes are reported with a valid-bit count. All outputs are registered, one cycle after the triggering input.

---
 rtl/deserialiser_pkg.sv | 12 +
 rtl/deserialiser.sv | 116 +++++++++++
 tb/tb_deserialiser.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/deserialiser_pkg.sv
// Shared receive-path definitions for the bit-to-byte deserialiser.
package deserialiser_pkg;

   localparam int unsigned BITS_PER_BYTE = 8;
   localparam int unsigned CNT_W         = $clog2(BITS_PER_BYTE);

   typedef enum logic {
      IDLE,
      RECEIVING
   } rx_state_t;

endpackage

// File: rtl/deserialiser.sv
// Packs an LSB-first bit stream from the frame decoder into bytes, reporting
// a valid-bit count for the trailing partial byte. All outputs registered.
module deserialiser
   import deserialiser_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_soc,
   input  logic                     in_eoc,
   input  logic                     in_data,
   input  logic                     in_data_valid,
   input  logic                     in_error,
   output logic                     out_soc,
   output logic                     out_eoc,
   output logic [BITS_PER_BYTE-1:0] out_data,
   output logic                     out_data_valid,
   output logic [CNT_W-1:0]         out_data_bits,
   output logic                     out_error
);

   rx_state_t                r_state, w_state_n;
   logic [CNT_W-1:0]         r_count, w_count_n;
   logic [BITS_PER_BYTE-1:0] r_shift, w_shift_n;

   logic                     r_soc, w_soc_n;
   logic                     r_eoc, w_eoc_n;
   logic                     r_dv, w_dv_n;
   logic [BITS_PER_BYTE-1:0] r_data, w_data_n;
   logic [CNT_W-1:0]         r_bits, w_bits_n;
   logic                     r_error, w_error_n;

   logic [BITS_PER_BYTE-1:0] w_shift_bit;
   logic [CNT_W-1:0]         w_count_inc;
   logic                     w_byte_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_count <= '0;
         r_shift <= '0;
         r_soc   <= 1'b0;
         r_eoc   <= 1'b0;
         r_dv    <= 1'b0;
         r_data  <= '0;
         r_bits  <= '0;
         r_error <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_count <= w_count_n;
         r_shift <= w_shift_n;
         r_soc   <= w_soc_n;
         r_eoc   <= w_eoc_n;
         r_dv    <= w_dv_n;
         r_data  <= w_data_n;
         r_bits  <= w_bits_n;
         r_error <= w_error_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_count_n = r_count;
      w_shift_n = r_shift;
      w_soc_n   = 1'b0;
      w_eoc_n   = 1'b0;
      w_dv_n    = 1'b0;
      w_data_n  = r_data;
      w_bits_n  = r_bits;
      w_error_n = r_error;

      // Register contents after accepting this cycle's bit; count wraps to 0 on a full byte.
      w_shift_bit = r_shift;
      if (in_data_valid) begin
         w_shift_bit[r_count] = in_data;
      end
      w_count_inc = r_count + CNT_W'(in_data_valid);
      w_byte_done = in_data_valid && (r_count == CNT_W'(BITS_PER_BYTE - 1));

      if (in_error) begin
         w_error_n = 1'b1;
         w_state_n = IDLE;
         w_count_n = '0;
         w_shift_n = '0;
      end else if (in_soc) begin
         w_state_n    = RECEIVING;
         w_soc_n      = 1'b1;
         w_error_n    = 1'b0;
         w_shift_n    = '0;
         w_shift_n[0] = in_data_valid & in_data;
         w_count_n    = CNT_W'(in_data_valid);
      end else if (r_state == RECEIVING) begin
         w_shift_n = w_shift_bit;
         w_count_n = w_count_inc;
         if (w_byte_done || (in_eoc && (w_count_inc != '0))) begin
            w_dv_n    = 1'b1;
            w_data_n  = w_shift_bit;
            w_bits_n  = w_count_inc;
            w_shift_n = '0;
         end
         if (in_eoc) begin
            w_eoc_n   = 1'b1;
            w_state_n = IDLE;
            w_count_n = '0;
            w_shift_n = '0;
         end
      end
   end

   assign out_soc        = r_soc;
   assign out_eoc        = r_eoc;
   assign out_data_valid = r_dv;
   assign out_data       = r_data;
   assign out_data_bits  = r_bits;
   assign out_error      = r_error;

endmodule

// File: tb/tb_deserialiser.sv
// Directed and randomised frame checks for the deserialiser against a
// bench-side byte model; output events are logged at the falling edge.
module tb_deserialiser;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_soc, in_eoc, in_data, in_data_valid, in_error;
   logic       out_soc, out_eoc, out_data_valid, out_error;
   logic [7:0] out_data;
   logic [2:0] out_data_bits;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   logic [11:0] mon_q[$];
   int unsigned mon_eoc = 0;
   int unsigned mon_soc = 0;
   int unsigned base_q, base_eoc, base_soc;

   deserialiser dut (
      .clk            (clk),
      .rst            (rst),
      .in_soc         (in_soc),
      .in_eoc         (in_eoc),
      .in_data        (in_data),
      .in_data_valid  (in_data_valid),
      .in_error       (in_error),
      .out_soc        (out_soc),
      .out_eoc        (out_eoc),
      .out_data       (out_data),
      .out_data_valid (out_data_valid),
      .out_data_bits  (out_data_bits),
      .out_error      (out_error)
   );

   always #5 clk = ~clk;

   // Entry layout: {eoc, bits[2:0], data[7:0]}
   always @(negedge clk) begin
      if (out_data_valid) mon_q.push_back({out_eoc, out_data_bits, out_data});
      if (out_eoc) mon_eoc++;
      if (out_soc) mon_soc++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic drive(input logic soc, input logic eoc, input logic dv, input logic d,
                        input logic err);
      @(negedge clk);
      in_soc        = soc;
      in_eoc        = eoc;
      in_data_valid = dv;
      in_data       = d;
      in_error      = err;
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic mark();
      base_q   = mon_q.size();
      base_eoc = mon_eoc;
      base_soc = mon_soc;
   endtask

   function automatic logic [11:0] entry(input int unsigned i);
      return (i < mon_q.size()) ? mon_q[i] : 12'hFFF;
   endfunction

   // merge: eoc shares the cycle of the last data bit
   task automatic send_frame(input logic [79:0] bits, input int unsigned n, input bit merge);
      mark();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int unsigned i = 0; i < n; i++) begin
         drive(1'b0, merge && (i == n - 1), 1'b1, bits[i], 1'b0);
         if (i == 0) check("soc_pulse", {31'd0, out_soc}, 32'd1);
      end
      if (!merge) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);
   endtask

   task automatic verify_frame(input logic [79:0] bits, input int unsigned n, input bit merge);
      int unsigned nb;
      int unsigned w;
      logic [7:0]  ed;
      logic [2:0]  eb;
      logic        ee;
      nb = (n + 7) / 8;
      check("nbytes", mon_q.size() - base_q, nb);
      for (int unsigned k = 0; k < nb; k++) begin
         w  = n - 8 * k;
         ed = bits[8*k +: 8];
         eb = 3'd0;
         if (w < 8) begin
            ed = ed & (8'hFF >> (8 - w));
            eb = 3'(w);
         end
         ee = (k == nb - 1) && (merge || (n % 8 != 0));
         check("byte", {20'd0, entry(base_q + k)}, {20'd0, ee, eb, ed});
      end
      check("neoc", mon_eoc - base_eoc, 1);
      check("nsoc", mon_soc - base_soc, 1);
   endtask

   initial begin
      logic [79:0] rb;
      int unsigned rn;
      bit          rm;

      rst = 1'b1;
      in_soc = 1'b0; in_eoc = 1'b0; in_data = 1'b0; in_data_valid = 1'b0; in_error = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_soc",   {31'd0, out_soc}, 0);
      check("rst_eoc",   {31'd0, out_eoc}, 0);
      check("rst_dv",    {31'd0, out_data_valid}, 0);
      check("rst_err",   {31'd0, out_error}, 0);
      check("rst_data",  {24'd0, out_data}, 0);
      check("rst_bits",  {29'd0, out_data_bits}, 0);
      rst = 1'b0;
      idle(2);

      // Bits arriving with no frame open are ignored
      mark();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(2);
      check("idle_ignore_dv",  mon_q.size() - base_q, 0);
      check("idle_ignore_eoc", mon_eoc - base_eoc, 0);

      // Two full bytes, eoc on last bit
      send_frame(80'h3CA5, 16, 1'b1);
      check("full_n",   mon_q.size() - base_q, 2);
      check("full_b0",  {20'd0, entry(base_q)},     {20'd0, 12'h0A5});
      check("full_b1",  {20'd0, entry(base_q + 1)}, {20'd0, 12'h83C});
      check("full_eoc", mon_eoc - base_eoc, 1);

      // Partial byte 1,0,1,1,0 -> 0x0D, 5 bits, separate eoc
      send_frame(80'b01101, 5, 1'b0);
      check("part_n",   mon_q.size() - base_q, 1);
      check("part_b",   {20'd0, entry(base_q)}, {20'd0, 12'hD0D});
      check("part_eoc", mon_eoc - base_eoc, 1);

      // soc with a bit in the same cycle stores it at position 0
      mark();
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);
      check("socdv_b", {20'd0, entry(base_q)}, {20'd0, 12'hB05});

      for (int unsigned n = 1; n <= 16; n++) begin
         send_frame(80'hC3_5A_96_E1_7B_24_D8_4F_A3_69, n, n[0]);
         verify_frame(80'hC3_5A_96_E1_7B_24_D8_4F_A3_69, n, n[0]);
      end

      for (int unsigned f = 0; f < 1000; f++) begin
         rb = {$urandom, $urandom, $urandom};
         rn = $urandom_range(80, 1);
         rm = 1'($urandom);
         send_frame(rb, rn, rm);
         verify_frame(rb, rn, rm);
      end

      // Error mid-frame, coinciding with eoc and a data bit
      mark();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int unsigned i = 0; i < 12; i++) begin
         rb = 80'h7E3;
         drive(1'b0, 1'b0, 1'b1, rb[i], 1'b0);
      end
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      idle(2);
      check("err_n",    mon_q.size() - base_q, 1);
      check("err_b",    {20'd0, entry(base_q)}, {20'd0, 12'h0E3});
      check("err_eoc",  mon_eoc - base_eoc, 0);
      check("err_flag", {31'd0, out_error}, 1);
      idle(5);
      check("err_sticky", {31'd0, out_error}, 1);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("err_clear",     {31'd0, out_error}, 0);
      check("err_clear_soc", {31'd0, out_soc}, 1);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);

      // Restart discards 3 partial bits
      mark();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int unsigned i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);
      check("rst_n",   mon_q.size() - base_q, 1);
      check("rst_b",   {20'd0, entry(base_q)}, {20'd0, 12'h0FF});
      check("rst_soc2", mon_soc - base_soc, 2);
      check("rst_eoc1", mon_eoc - base_eoc, 1);

      // Asynchronous reset mid-frame
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int unsigned i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      in_soc = 1'b0; in_eoc = 1'b0; in_data = 1'b0; in_data_valid = 1'b0; in_error = 1'b0;
      #1;
      check("arst_data", {24'd0, out_data}, 0);
      check("arst_bits", {29'd0, out_data_bits}, 0);
      check("arst_dv",   {31'd0, out_data_valid}, 0);
      check("arst_soc",  {31'd0, out_soc}, 0);
      check("arst_eoc",  {31'd0, out_eoc}, 0);
      check("arst_err",  {31'd0, out_error}, 0);
      @(negedge clk);
      rst = 1'b0;
      mark();
      for (int unsigned i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);
      check("arst_quiet_dv",  mon_q.size() - base_q, 0);
      check("arst_quiet_eoc", mon_eoc - base_eoc, 0);
      check("arst_quiet_soc", mon_soc - base_soc, 0);
      send_frame(80'h5A, 8, 1'b1);
      verify_frame(80'h5A, 8, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
